// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared mode constants, FSM state type and width helpers for the serial-audio receiver
package i2s_rx_pkg;

  localparam logic [1:0] MODE_I2S = 2'd0;
  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_TDM = 2'd2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } rx_state_t;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int cnt_w(input int slot_w);
    return $clog2(slot_w + 1);
  endfunction

  function automatic int entry_w(input int dw, input int chw);
    return dw + chw + 1;
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - first-word-fall-through sample FIFO; a write while full is taken only alongside a read
module i2s_rx_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         sclk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head is masked while empty so the stream outputs read zero out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/i2s_tdm_rx.sv
// rtl/i2s_tdm_rx.sv - I2S / left-justified / TDM receiver emitting channel-tagged samples on a valid/ready stream
module i2s_tdm_rx
  import i2s_rx_pkg::*;
#(
  parameter int AUDIO_DW   = 16,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CHW        = ch_w(NUM_CH)
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] out_data,
  output logic [CHW-1:0]      out_ch,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic                frame_err,
  input  logic                clr_err
);

  localparam int CNTW = cnt_w(SLOT_W);
  localparam int EW   = entry_w(AUDIO_DW, CHW);

  localparam logic [CNTW-1:0] CNT_DW   = CNTW'(AUDIO_DW);
  localparam logic [CNTW-1:0] CNT_SLOT = CNTW'(SLOT_W);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CH - 1);
  localparam logic [CHW-1:0]  CH_ONE   = CHW'(1);

  rx_state_t           state;
  logic                lrclk_r;
  logic [1:0]          mode_r;
  logic                rise_d;
  logic                fall_d;
  logic                edge_d;
  logic [CHW-1:0]      ch;
  logic [CNTW-1:0]     bitcnt;
  logic [AUDIO_DW-1:0] sr;

  logic                rise;
  logic                fall;
  logic                lr_edge;
  logic                is_tdm;
  logic                mode_chg;
  logic                fstart;
  logic                bnd;

  logic                cap;
  logic                stop;
  logic                err_evt;
  logic [CNTW-1:0]     slot_cnt;
  logic [CHW-1:0]      slot_ch;
  logic [CNTW-1:0]     new_cnt;
  logic [AUDIO_DW-1:0] sr_new;
  logic                slot_last;
  logic                push;
  logic                pop;
  logic                ovf_evt;

  logic [EW-1:0]       fifo_wr;
  logic [EW-1:0]       fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;

  assign rise     = lrclk && !lrclk_r;
  assign fall     = !lrclk && lrclk_r;
  assign lr_edge  = lrclk ^ lrclk_r;
  assign is_tdm   = (mode == MODE_TDM);
  assign mode_chg = (mode != mode_r);

  // I2S and DSP-A put the MSB one bit after the lrclk edge, so their slot starts use the delayed edges.
  always_comb begin
    fstart = 1'b0;
    bnd    = 1'b0;
    case (mode)
      MODE_LJ: begin
        fstart = rise;
        bnd    = lr_edge;
      end
      MODE_TDM: begin
        fstart = rise_d;
        bnd    = 1'b0;
      end
      default: begin
        fstart = fall_d;
        bnd    = edge_d;
      end
    endcase
  end

  always_comb begin
    cap      = 1'b0;
    stop     = 1'b0;
    err_evt  = 1'b0;
    slot_cnt = bitcnt;
    slot_ch  = ch;
    if (mode_chg) begin
      cap = 1'b0;
    end else if (state == HUNT) begin
      if (fstart) begin
        cap      = 1'b1;
        slot_cnt = '0;
        slot_ch  = '0;
      end
    end else if (fstart) begin
      err_evt  = is_tdm ? !((ch == CH_LAST) && (bitcnt == CNT_SLOT)) : (bitcnt < CNT_DW);
      cap      = 1'b1;
      slot_cnt = '0;
      slot_ch  = '0;
    end else if (bnd) begin
      err_evt  = (bitcnt < CNT_DW);
      cap      = 1'b1;
      slot_cnt = '0;
      slot_ch  = CH_ONE;
    end else if (is_tdm && (bitcnt == CNT_SLOT)) begin
      if (ch == CH_LAST) begin
        err_evt = 1'b1;
        stop    = 1'b1;
      end else begin
        cap      = 1'b1;
        slot_cnt = '0;
        slot_ch  = ch + CH_ONE;
      end
    end else if (bitcnt < CNT_SLOT) begin
      cap = 1'b1;
    end
  end

  assign new_cnt   = slot_cnt + CNTW'(1);
  assign sr_new    = {sr[AUDIO_DW-2:0], sdata};
  assign slot_last = is_tdm ? (slot_ch == CH_LAST) : (slot_ch == CH_ONE);
  assign push      = cap && (new_cnt == CNT_DW);
  assign pop       = out_valid && out_ready;
  assign ovf_evt   = push && fifo_full && !pop;
  assign fifo_wr   = {sr_new, slot_ch, slot_last};

  always_ff @(posedge sclk) begin
    lrclk_r <= lrclk;
    if (rst) begin
      mode_r    <= mode;
      rise_d    <= 1'b0;
      fall_d    <= 1'b0;
      edge_d    <= 1'b0;
      state     <= HUNT;
      ch        <= '0;
      bitcnt    <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mode_r <= mode;
      rise_d <= rise;
      fall_d <= fall;
      edge_d <= lr_edge;
      if (mode_chg || stop) begin
        state <= HUNT;
      end else if ((state == HUNT) && fstart) begin
        state <= RUN;
      end
      if (cap) begin
        ch     <= slot_ch;
        bitcnt <= new_cnt;
        if (slot_cnt < CNT_DW) sr <= sr_new;
      end
      if (err_evt) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

  i2s_rx_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sclk    (sclk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (fifo_wr),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {out_data, out_ch, out_last} = fifo_rd;
  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// tb/tb_i2s_tdm_rx.sv - scoreboard bench for i2s_tdm_rx covering I2S, LJ, TDM, framing errors, overflow and reset
module tb_i2s_tdm_rx;
  import i2s_rx_pkg::*;

  localparam int DW  = 16;
  localparam int SW  = 32;
  localparam int NCH = 8;
  localparam int FD  = 4;
  localparam int CHW = 3;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = MODE_I2S;
  logic          lrclk = 1'b1;
  logic          sdata = 1'b0;
  logic [DW-1:0] out_data;
  logic [CHW-1:0] out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          overflow;
  logic          frame_err;
  logic          clr_err = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int lat_ref = 0;
  int lat_exp = 0;
  bit lat_arm = 1'b0;
  logic [DW+CHW:0] sb[$];

  i2s_tdm_rx #(
    .AUDIO_DW   (DW),
    .SLOT_W     (SW),
    .NUM_CH     (NCH),
    .FIFO_DEPTH (FD)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .mode      (mode),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic tx(input logic lr, input logic d);
    @(posedge sclk);
    #2;
    lrclk = lr;
    sdata = d;
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input int ch, input logic last);
    sb.push_back({d, CHW'(ch), last});
  endtask

  // One stereo frame of two SW-bit halves; I2S data lags lrclk by one bit, LJ does not.
  task automatic i2s_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit lj, input bit arm);
    for (int p = 0; p < 2*SW; p++) begin
      int q;
      logic [DW-1:0] w;
      logic d;
      logic lr;
      q = lj ? p : p - 1;
      d = 1'b0;
      if (q >= 0) begin
        w = (q < SW) ? l : r;
        if ((q % SW) < DW) d = w[DW-1-(q % SW)];
      end
      lr = lj ? (p < SW) : (p >= SW);
      tx(lr, d);
      if (p == 0 && arm) begin
        lat_ref = cyc + 1;
        lat_exp = lj ? 16 : 17;
        lat_arm = 1'b1;
      end
    end
  endtask

  task automatic tdm_frame(input logic [DW-1:0] base, input int nslots);
    for (int p = 0; p < nslots*SW; p++) begin
      int q;
      logic [DW-1:0] w;
      logic d;
      q = p - 1;
      d = 1'b0;
      if (q >= 0 && (q % SW) < DW) begin
        w = base + DW'(q / SW);
        d = w[DW-1-(q % SW)];
      end
      tx(p == 0, d);
    end
  endtask

  initial begin
    logic [DW+CHW:0] e;
    forever begin
      @(negedge sclk);
      if (!rst && out_valid) begin
        if (lat_arm) begin
          chk("latency", cyc + 1 - lat_ref, lat_exp);
          lat_arm = 1'b0;
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: got data=%h ch=%0d, expected no output", out_data, out_ch);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e[DW+CHW:CHW+1]);
            chk("out_ch", out_ch, e[CHW:1]);
            chk("out_last", out_last, e[0]);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) tx(1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    repeat (4) tx(1'b1, 1'b0);

    expect_word(16'hA5C3, 0, 1'b0);
    expect_word(16'h1234, 1, 1'b1);
    i2s_frame(16'hA5C3, 16'h1234, 1'b0, 1'b1);

    mode = MODE_LJ;
    repeat (4) tx(1'b0, 1'b0);
    expect_word(16'hA5C3, 0, 1'b0);
    expect_word(16'h1234, 1, 1'b1);
    i2s_frame(16'hA5C3, 16'h1234, 1'b1, 1'b1);
    chk("frame_err_after_lj", frame_err, 0);

    mode = MODE_TDM;
    repeat (4) tx(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) expect_word(16'h1000 + DW'(k), k, k == 7);
    tdm_frame(16'h1000, 8);
    for (int k = 0; k < 6; k++) expect_word(16'h2000 + DW'(k), k, 1'b0);
    tdm_frame(16'h2000, 6);
    chk("frame_err_full_tdm", frame_err, 0);
    for (int k = 0; k < 8; k++) expect_word(16'h3000 + DW'(k), k, k == 7);
    tdm_frame(16'h3000, 8);
    mode = MODE_I2S;
    tx(1'b1, 1'b0);
    chk("frame_err_short_tdm", frame_err, 1);
    clr_err = 1'b1;
    tx(1'b1, 1'b0);
    clr_err = 1'b0;
    tx(1'b1, 1'b0);
    chk("frame_err_cleared", frame_err, 0);

    repeat (4) tx(1'b1, 1'b0);
    out_ready = 1'b0;
    expect_word(16'hC001, 0, 1'b0);
    expect_word(16'hC002, 1, 1'b1);
    expect_word(16'hC003, 0, 1'b0);
    expect_word(16'hC004, 1, 1'b1);
    i2s_frame(16'hC001, 16'hC002, 1'b0, 1'b0);
    i2s_frame(16'hC003, 16'hC004, 1'b0, 1'b0);
    i2s_frame(16'hC005, 16'hC006, 1'b0, 1'b0);
    repeat (4) tx(1'b1, 1'b0);
    chk("ovf_held_valid", out_valid, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_held_data", out_data, 16'hC001);
    chk("ovf_held_ch", out_ch, 0);
    chk("ovf_frame_err", frame_err, 0);
    out_ready = 1'b1;
    repeat (8) tx(1'b1, 1'b0);
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    tx(1'b1, 1'b0);
    clr_err = 1'b0;
    tx(1'b1, 1'b0);
    chk("ovf_cleared", overflow, 0);

    out_ready = 1'b0;
    i2s_frame(16'hD001, 16'hD002, 1'b0, 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    for (int p = 0; p < 10; p++) tx(1'b0, 1'b1);
    rst = 1'b1;
    tx(1'b0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_ch", out_ch, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    out_ready = 1'b1;
    for (int p = 11; p < SW; p++) tx(1'b0, 1'b1);
    for (int p = 0; p < SW; p++) tx(1'b1, 1'b1);
    chk("no_push_after_rst", out_valid, 0);
    expect_word(16'hD005, 0, 1'b0);
    expect_word(16'hD006, 1, 1'b1);
    i2s_frame(16'hD005, 16'hD006, 1'b0, 1'b0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) tx(1'b1, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
